// File: rtl/apb_master_pkg.sv
// apb_master_pkg
//   Shared types and sizing helpers for the APB4 master bridge and its
//   address decoder.
//   - apb_state_e   : bridge FSM states.
//   - SEL_W/STRB_W  : select-index and strobe widths at the default
//                     configuration (8 completers, 32-bit data).
//   - apb_rsp_t     : response record {rdata, err} at the default data width.
//   - sel_width()   : index width for a given completer count, never below 1.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DECERR = 2'd3
    } apb_state_e;

    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int SEL_W  = 3;
    localparam int STRB_W = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } apb_rsp_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder
//   Purely combinational completer select. Turns the slave index field of an
//   address into a one-hot select vector and flags indices with no completer
//   behind them. Shared with the scoreboard reference model.
//   Ports:
//     idx          in  SEL_W      slave index field
//     sel          out SLAVE_NUM  one-hot select (all zero when out of range)
//     out_of_range out 1          idx >= SLAVE_NUM
module apb_addr_decoder
    import apb_master_pkg::*;
#(
    parameter int SLAVE_NUM = 8,
    parameter int IDX_W     = sel_width(SLAVE_NUM)
) (
    input  logic [IDX_W-1:0]     idx,
    output logic [SLAVE_NUM-1:0] sel,
    output logic                 out_of_range
);

    for (genvar i = 0; i < SLAVE_NUM; i++) begin : g_sel
        assign sel[i] = (idx == IDX_W'(i));
    end

    // One extra bit so the compare works when SLAVE_NUM == 2**IDX_W.
    assign out_of_range = ({1'b0, idx} >= (IDX_W + 1)'(SLAVE_NUM));

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   APB4 requester. Takes one transfer at a time from a valid/ready request
//   port, runs SETUP then ACCESS on the APB bus, waits for pready (bounded
//   by TIMEOUT_CYCLES), and reports completion on a one-cycle rsp_valid pulse.
//   Ports:
//     pclk, preset_n                    clock, async active-low reset
//     req_valid/req_ready               request handshake
//     req_write/addr/wdata/strb/prot    request payload
//     rsp_valid/rsp_rdata/rsp_err       completion pulse and held result
//     paddr/pwdata/pwrite/penable/psel/pstrb/pprot  APB outputs (registered)
//     prdata/pready/pslverr             APB completer response
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SLAVE_NUM      = 8,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    // request side
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic [2:0]              req_prot,
    // response side
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    // APB bus
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic                    pwrite,
    output logic                    penable,
    output logic [SLAVE_NUM-1:0]    psel,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int IDX_W = sel_width(SLAVE_NUM);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } rsp_t;

    apb_state_e       state;
    logic [CNT_W-1:0] wait_cnt;
    rsp_t             rsp_q;

    logic [SLAVE_NUM-1:0] dec_sel;
    logic                 dec_err;

    apb_addr_decoder #(
        .SLAVE_NUM (SLAVE_NUM),
        .IDX_W     (IDX_W)
    ) u_dec (
        .idx          (req_addr[SEL_LSB +: IDX_W]),
        .sel          (dec_sel),
        .out_of_range (dec_err)
    );

    // Ready is a decode of the state register, so it is glitch-free and
    // high as soon as the bridge sits in IDLE (including right after reset).
    assign req_ready = (state == IDLE);
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            penable   <= 1'b0;
            psel      <= '0;
            pstrb     <= '0;
            pprot     <= '0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        paddr    <= req_addr;
                        pwrite   <= req_write;
                        pprot    <= req_prot;
                        // Reads never carry data or strobes onto the bus.
                        pwdata   <= req_write ? req_wdata : '0;
                        pstrb    <= req_write ? req_strb  : '0;
                        wait_cnt <= '0;
                        if (dec_err) begin
                            state <= DECERR;
                        end else begin
                            psel  <= dec_sel;
                            state <= SETUP;
                        end
                    end
                end

                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (penable && pready) begin
                        rsp_valid   <= 1'b1;
                        rsp_q.err   <= pslverr;
                        rsp_q.rdata <= (!pwrite && !pslverr) ? prdata : '0;
                        psel        <= '0;
                        penable     <= 1'b0;
                        state       <= IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Completer never answered: abandon the transfer.
                        rsp_valid   <= 1'b1;
                        rsp_q.err   <= 1'b1;
                        rsp_q.rdata <= '0;
                        psel        <= '0;
                        penable     <= 1'b0;
                        state       <= IDLE;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                DECERR: begin
                    rsp_valid   <= 1'b1;
                    rsp_q.err   <= 1'b1;
                    rsp_q.rdata <= '0;
                    state       <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB4 initiator (requester) that drives the shared APB bus towards up to SLAVE_NUM completers (e.g. SPI register block).
- Accepts single transfers on a simple valid/ready request port from the MCU core side.
- Runs the SETUP/ACCESS sequence, decodes paddr into a one-hot psel, honours pready wait states with a timeout, and returns read data and an error flag on a response pulse.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width (strobe width is DATA_WIDTH/8).
- SLAVE_NUM, 8, number of completers; psel width.
- SEL_LSB, 12, lowest address bit of the slave index field req_addr[SEL_LSB +: SEL_W].
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without pready before forced termination.

Ports:
- pclk  in  1  bus clock; all logic on rising edge.
- preset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  write data.
- req_strb  in  DATA_WIDTH/8  write byte strobes.
- req_prot  in  3  protection attributes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  pslverr, decode error, or timeout.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pwrite  out  1  APB direction.
- penable  out  1  APB access phase.
- psel  out  SLAVE_NUM  one-hot completer select.
- pstrb  out  4  APB write strobes; width is DATA_WIDTH/8, which is 4 at the default.
- pprot  out  3  APB protection.
- prdata  in  DATA_WIDTH  completer read data.
- pready  in  1  completer ready.
- pslverr  in  1  completer error.

Behaviour:
- Reset:
  - Asynchronous on preset_n low; all outputs 0 except req_ready, which is 1 once out of reset.
  - State IDLE; timeout counter 0.
  - Reset asserted mid-transfer aborts it: psel/penable drop immediately and no rsp_valid is issued.
- FSM states IDLE, SETUP, ACCESS, DECERR.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch addr/wdata/strb/prot/write into the APB output registers.
  - Compute idx=req_addr[SEL_LSB +: SEL_W].
  - idx<SLAVE_NUM: go to SETUP; idx>=SLAVE_NUM: go to DECERR.
- SETUP (1 cycle):
  - psel[idx]=1, penable=0, req_ready=0.
  - Always go to ACCESS.
- ACCESS:
  - penable=1; psel, paddr, pwrite, pwdata, pstrb and pprot held stable.
  - pready=1: capture prdata (reads only) and pslverr; next cycle rsp_valid=1, rsp_err=pslverr; clear psel/penable; go to IDLE.
  - pready=0: increment counter.
  - Counter reaching TIMEOUT_CYCLES-1 with pready still 0: terminate with rsp_valid=1, rsp_err=1, rsp_rdata=0; clear psel/penable; go to IDLE.
- DECERR (1 cycle):
  - No APB activity; psel stays 0.
  - Next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; go to IDLE.
- Reads drive pstrb=0 and pwdata=0; writes return rsp_rdata=0.
- pslverr and prdata are sampled only when penable&&pready.
- Latency with zero wait states:
  - Accept edge T; SETUP in T+1; ACCESS in T+2; rsp_valid in T+3.
  - req_ready=1 again in T+3, so a new request may be accepted at the T+3 edge.
- rsp_valid is a single-cycle pulse with no backpressure; rsp_rdata/rsp_err hold until the next response.
- SEL_W=$clog2(SLAVE_NUM), minimum 1.
- TIMEOUT counter width is $clog2(TIMEOUT_CYCLES)+1 and saturates, never wrapping.

Decomposition:
- Package apb_master_pkg: state enum (IDLE, SETUP, ACCESS, DECERR), SEL_W and STRB_W localparams, rsp struct {rdata, err}.
- Sub-module apb_addr_decoder: combinational idx-to-one-hot psel plus out-of-range flag, reused by the UVC scoreboard reference model.

Test Plan:
- Write addr 0x0000_2010, wdata 0xDEAD_BEEF, strb 0xF, pready=1 -> psel=0x04 in T+1 with penable=0; penable=1 in T+2; rsp_valid, rsp_err=0 in T+3.
- Read addr 0x0000_1004, 3 wait states, prdata=0x1234_5678 -> penable high 4 cycles; signals stable; rsp_rdata=0x1234_5678, pstrb=0 throughout.
- Read with pready=1, pslverr=1 -> rsp_err=1, rsp_rdata=0, return to IDLE, req_ready=1.
- pready held 0 -> exactly 16 ACCESS cycles, then psel=0, rsp_valid with rsp_err=1.
- SLAVE_NUM=6, addr 0x0000_7000 (idx 7) -> psel never asserted; rsp_err=1 two cycles after accept.
- preset_n low during ACCESS, then released -> psel/penable 0 asynchronously; no rsp_valid; next request completes normally.
